// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch control path.
// FSM encoding, default reset PC and slot-valid encodings.
package ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_DROP = 2'd3
  } ifu_fetch_state_e;

  localparam logic [63:0] IFU_DEFAULT_RESET_PC = 64'h8000_0000;

  localparam logic [1:0] SLOT_BOTH = 2'b11;
  localparam logic [1:0] SLOT_ONE  = 2'b01;
  localparam logic [1:0] SLOT_NONE = 2'b00;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-control bundle: buffer refill/redirect inputs, memory read channel, aligned output.
// master = fetch controller side, slave = instruction buffer / memory side.
interface ifu_fetch_ctrl_if #(
  parameter int PC_WIDTH = 64
);
  logic                fetch_inst;
  logic                mem_stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                pc_index_valid;
  logic [PC_WIDTH-1:0] pc_index;
  logic                pc_index_ready;
  logic [63:0]         pc_read_inst;
  logic                pc_operation_done;
  logic [63:0]         aligned_instr;
  logic [1:0]          aligned_instr_valid;
  logic [PC_WIDTH-1:0] pc;
  logic                clear_ibuffer;

  modport master (
    input  fetch_inst, mem_stall, redirect_valid, redirect_target,
    input  pc_index_ready, pc_read_inst, pc_operation_done,
    output pc_index_valid, pc_index, aligned_instr, aligned_instr_valid, pc, clear_ibuffer
  );

  modport slave (
    output fetch_inst, mem_stall, redirect_valid, redirect_target,
    output pc_index_ready, pc_read_inst, pc_operation_done,
    input  pc_index_valid, pc_index, aligned_instr, aligned_instr_valid, pc, clear_ibuffer
  );
endinterface

// File: rtl/ifu_fetch_ctrl_slot_align.sv
// fetch_slot_align: combinational doubleword-to-slot aligner, zero latency, no backpressure.
// A PC at the upper word of a doubleword yields a single slot in the low half.
module fetch_slot_align
  import ifu_pkg::*;
(
  input  logic [63:0] dword_i,
  input  logic        pc_bit2_i,
  output logic [63:0] instr_o,
  output logic [1:0]  valid_o
);

  always_comb begin
    if (pc_bit2_i) begin
      instr_o = {32'd0, dword_i[63:32]};
      valid_o = SLOT_ONE;
    end else begin
      instr_o = dword_i;
      valid_o = SLOT_BOTH;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch PC holder and 64-bit read requester; data to aligned output in 1 cycle, request held until pc_index_ready, mem_stall blocks new requests.
// Optional IFU_FETCH_PERF_EN adds handshake/redirect/drop counters.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = IFU_DEFAULT_RESET_PC[PC_WIDTH-1:0]
) (
  input  logic                 clock,
  input  logic                 reset,
  ifu_fetch_ctrl_if.master     bus
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_redirect_cnt,
  output logic [31:0]          perf_drop_cnt
`endif
);

  ifu_fetch_state_e    state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic                pending_q, pending_d;
  logic [63:0]         aligned_instr_q;
  logic [1:0]          aligned_valid_q;
  logic                clear_q;
  logic                req_vld;
  logic                hs;
  logic                take_data;
  logic                drop_data;
  logic [63:0]         align_instr;
  logic [1:0]          align_valid;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IFU_IDLE;
    else       state_q <= state_d;
  end

  // A redirect in DROP leaves the drop in progress; the owed response still exits it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE: begin
        if (!bus.redirect_valid && (pending_q || bus.fetch_inst) && !bus.mem_stall)
          state_d = IFU_REQ;
      end
      IFU_REQ: begin
        if (bus.pc_index_ready)     state_d = bus.redirect_valid ? IFU_DROP : IFU_WAIT;
        else if (bus.redirect_valid) state_d = IFU_IDLE;
      end
      IFU_WAIT: begin
        if (bus.pc_operation_done)   state_d = IFU_IDLE;
        else if (bus.redirect_valid) state_d = IFU_DROP;
      end
      IFU_DROP: begin
        if (bus.pc_operation_done)   state_d = IFU_IDLE;
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_comb begin
    req_vld   = (state_q == IFU_REQ);
    hs        = req_vld && bus.pc_index_ready;
    take_data = (state_q == IFU_WAIT) && bus.pc_operation_done && !bus.redirect_valid;
    drop_data = bus.pc_operation_done &&
                ((state_q == IFU_DROP) || ((state_q == IFU_WAIT) && bus.redirect_valid));
  end

  fetch_slot_align u_align (
    .dword_i   (bus.pc_read_inst),
    .pc_bit2_i (fetch_pc_q[2]),
    .instr_o   (align_instr),
    .valid_o   (align_valid)
  );

  always_comb begin
    pending_d = pending_q;
    if (bus.fetch_inst) pending_d = 1'b1;
    else if (hs)        pending_d = 1'b0;
    if (bus.redirect_valid) pending_d = 1'b1;

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_target;
    else if (take_data)     fetch_pc_d = {fetch_pc_q[PC_WIDTH-1:3], 3'b000} + PC_WIDTH'(8);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q      <= RESET_PC;
      pending_q       <= 1'b1;
      pc_q            <= '0;
      aligned_instr_q <= '0;
      aligned_valid_q <= SLOT_NONE;
      clear_q         <= 1'b0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      pending_q       <= pending_d;
      clear_q         <= bus.redirect_valid;
      aligned_valid_q <= take_data ? align_valid : SLOT_NONE;
      if (take_data) begin
        aligned_instr_q <= align_instr;
        pc_q            <= fetch_pc_q;
      end
    end
  end

  assign bus.pc_index_valid      = req_vld;
  assign bus.pc_index            = {fetch_pc_q[PC_WIDTH-1:3], 3'b000};
  assign bus.aligned_instr       = aligned_instr_q;
  assign bus.aligned_instr_valid = aligned_valid_q;
  assign bus.pc                  = pc_q;
  assign bus.clear_ibuffer       = clear_q;

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_redirect_q, perf_drop_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q    <= '0;
      perf_redirect_q <= '0;
      perf_drop_q     <= '0;
    end else begin
      if (hs)                 perf_fetch_q    <= perf_fetch_q + 32'd1;
      if (bus.redirect_valid) perf_redirect_q <= perf_redirect_q + 32'd1;
      if (drop_data)          perf_drop_q     <= perf_drop_q + 32'd1;
    end
  end

  assign perf_fetch_cnt    = perf_fetch_q;
  assign perf_redirect_cnt = perf_redirect_q;
  assign perf_drop_cnt     = perf_drop_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_ifu_fetch_ctrl;
  import ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ifu_fetch_ctrl_if #(.PC_WIDTH(64)) bus ();

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_drop_cnt;
`endif

  ifu_fetch_ctrl #(.PC_WIDTH(64), .RESET_PC(RST_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef IFU_FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_drop_cnt     (perf_drop_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: a fetch address, an owed-refill flag,
  // whether a request is on offer, and whether one is outstanding (and doomed).
  logic [63:0] m_pc;
  bit          m_pending, m_req, m_out, m_discard, m_clear;
  logic [1:0]  m_valid;
  logic [63:0] m_instr, m_opc;
  logic [31:0] m_nfetch, m_nredir, m_ndrop;

  task automatic model_step(input bit rst, input bit fi, input bit stall, input bit rv,
                            input logic [63:0] rt, input bit rdy, input bit done,
                            input logic [63:0] data);
    bit hs, was_out, want;
    if (rst) begin
      m_pc = RST_PC; m_pending = 1; m_req = 0; m_out = 0; m_discard = 0; m_clear = 0;
      m_valid = 2'b00; m_instr = '0; m_opc = '0;
      m_nfetch = '0; m_nredir = '0; m_ndrop = '0;
      return;
    end
    hs      = m_req && rdy;
    was_out = m_out;
    want    = m_pending || fi;
    m_valid = 2'b00;
    m_clear = rv;
    if (m_out && done) begin
      if (m_discard || rv) begin
        m_ndrop++;
      end else begin
        // Instruction words live at 4-byte addresses; the doubleword holds pc&~7 and (pc&~7)+4.
        if (m_pc % 8 == 4) begin m_instr = {32'd0, data[63:32]}; m_valid = 2'b01; end
        else               begin m_instr = data;                 m_valid = 2'b11; end
        m_opc = m_pc;
        m_pc  = m_pc - (m_pc % 8) + 64'd8;
      end
      m_out = 0;
    end
    m_pending = fi ? 1'b1 : (hs ? 1'b0 : m_pending);
    if (hs) begin
      m_req = 0; m_out = 1; m_discard = rv; m_nfetch++;
    end else if (!m_req && !was_out && want && !stall && !rv) begin
      m_req = 1;
    end
    if (rv) begin
      m_req = 0;
      if (m_out) m_discard = 1;
      m_pc = rt;
      m_pending = 1;
      m_nredir++;
    end
  endtask

  task automatic cyc(input bit rst, input bit fi, input bit stall, input bit rv,
                     input logic [63:0] rt, input bit rdy, input bit done,
                     input logic [63:0] data);
    reset                 = rst;
    bus.fetch_inst        = fi;
    bus.mem_stall         = stall;
    bus.redirect_valid    = rv;
    bus.redirect_target   = rt;
    bus.pc_index_ready    = rdy;
    bus.pc_operation_done = done;
    bus.pc_read_inst      = data;
    @(posedge clock);
    model_step(rst, fi, stall, rv, rt, rdy, done, data);
    #1;
    chk("pc_index_valid", 64'(bus.pc_index_valid), 64'(m_req));
    chk("pc_index", bus.pc_index, m_pc & ~64'd7);
    chk("clear_ibuffer", 64'(bus.clear_ibuffer), 64'(m_clear));
    chk("aligned_valid", 64'(bus.aligned_instr_valid), 64'(m_valid));
    chk("aligned_instr", bus.aligned_instr, m_instr);
    chk("pc", bus.pc, m_opc);
`ifdef IFU_FETCH_PERF_EN
    chk("perf_fetch", 64'(perf_fetch_cnt), 64'(m_nfetch));
    chk("perf_redirect", 64'(perf_redirect_cnt), 64'(m_nredir));
    chk("perf_drop", 64'(perf_drop_cnt), 64'(m_ndrop));
`endif
  endtask

  task automatic idle(input bit fi, input bit stall, input bit rdy);
    cyc(0, fi, stall, 0, '0, rdy, 0, '0);
  endtask

  task automatic done_with(input logic [63:0] data);
    cyc(0, 0, 0, 0, '0, 0, 1, data);
  endtask

  task automatic redirect(input logic [63:0] rt);
    cyc(0, 0, 0, 1, rt, 0, 0, '0);
  endtask

  bit          r_rst, r_fi, r_stall, r_rv, r_rdy, r_done;
  logic [63:0] r_rt, r_dat, held_idx;

  initial begin
    cyc(1, 0, 0, 0, '0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0, 0, 0, '0);
    chk("rst_index_valid", 64'(bus.pc_index_valid), 64'd0);
    chk("rst_index", bus.pc_index, 64'h8000_0000);
    chk("rst_valid", 64'(bus.aligned_instr_valid), 64'd0);
    chk("rst_pc", bus.pc, 64'd0);
    chk("rst_clear", 64'(bus.clear_ibuffer), 64'd0);

    // Basic fetch: two slots from the reset PC.
    idle(1, 0, 0);
    chk("t1_req", 64'(bus.pc_index_valid), 64'd1);
    chk("t1_index", bus.pc_index, 64'h8000_0000);
    idle(0, 0, 1);
    idle(0, 0, 0);
    done_with(64'hAAAA_BBBB_1111_2222);
    chk("t1_valid", 64'(bus.aligned_instr_valid), 64'(SLOT_BOTH));
    chk("t1_instr", bus.aligned_instr, 64'hAAAA_BBBB_1111_2222);
    chk("t1_pc", bus.pc, 64'h8000_0000);
    chk("t1_next", bus.pc_index, 64'h8000_0008);

    // Redirect to an odd word: single slot.
    redirect(64'h8000_0104);
    chk("t2_clear", 64'(bus.clear_ibuffer), 64'd1);
    chk("t2_noreq", 64'(bus.pc_index_valid), 64'd0);
    idle(0, 0, 0);
    chk("t2_clear_off", 64'(bus.clear_ibuffer), 64'd0);
    chk("t2_req", 64'(bus.pc_index_valid), 64'd1);
    idle(0, 0, 1);
    done_with(64'h1234_5678_9ABC_DEF0);
    chk("t2_valid", 64'(bus.aligned_instr_valid), 64'(SLOT_ONE));
    chk("t2_instr", bus.aligned_instr, 64'h0000_0000_1234_5678);
    chk("t2_pc", bus.pc, 64'h8000_0104);
    chk("t2_next", bus.pc_index, 64'h8000_0108);

    // Redirect while waiting: the old response is dropped.
    idle(1, 0, 0);
    idle(0, 0, 1);
    redirect(64'h8000_0200);
    done_with(64'hDEAD_BEEF_DEAD_BEEF);
    chk("t3_dropped", 64'(bus.aligned_instr_valid), 64'd0);
    idle(0, 0, 0);
    chk("t3_req", 64'(bus.pc_index_valid), 64'd1);
    chk("t3_index", bus.pc_index, 64'h8000_0200);
    idle(0, 0, 1);
    done_with(64'h0102_0304_0506_0708);

    // Stall holds off the request.
    idle(1, 1, 0);
    for (int i = 0; i < 4; i++) idle(0, 1, 0);
    chk("t4_stalled", 64'(bus.pc_index_valid), 64'd0);
    idle(0, 0, 0);
    chk("t4_req", 64'(bus.pc_index_valid), 64'd1);

    // Ready withheld: request stable, single handshake.
    held_idx = bus.pc_index;
    for (int i = 0; i < 3; i++) begin
      idle(0, 0, 0);
      chk("t5_hold_vld", 64'(bus.pc_index_valid), 64'd1);
      chk("t5_hold_idx", bus.pc_index, held_idx);
    end
    idle(0, 0, 1);
    chk("t5_one_hs", 64'(bus.pc_index_valid), 64'd0);
    idle(0, 0, 1);
    chk("t5_no_second", 64'(bus.pc_index_valid), 64'd0);
    done_with(64'h1111_1111_2222_2222);

    // Wrap at the top of the address space.
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    idle(0, 0, 0);
    idle(0, 0, 1);
    done_with(64'h5555_6666_7777_8888);
    chk("t6_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("t6_wrap", bus.pc_index, 64'd0);

    // Reset mid-transaction, then a late response that must be ignored.
    idle(1, 0, 0);
    idle(0, 0, 1);
    cyc(1, 0, 0, 0, '0, 0, 0, '0);
    done_with(64'h9999_9999_9999_9999);
    chk("t7_late_done", 64'(bus.aligned_instr_valid), 64'd0);

    for (int i = 0; i < 4000; i++) begin
      r_rst   = ($urandom_range(0, 299) == 0);
      r_fi    = ($urandom_range(0, 3) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_rv    = ($urandom_range(0, 15) == 0);
      r_rt    = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
      if ($urandom_range(0, 3) == 0) r_rt = 64'hFFFF_FFFF_FFFF_FFF0 | (r_rt & 64'hC);
      r_rdy   = ($urandom_range(0, 1) == 1);
      r_done  = m_out ? ($urandom_range(0, 2) == 0)
                      : (!m_req && ($urandom_range(0, 15) == 0));
      r_dat   = {$urandom, $urandom};
      cyc(r_rst, r_fi, r_stall, r_rv, r_rt, r_rdy, r_done, r_dat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
